// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared types and default sizes for the multi-port register file.
//   state_t        : clear-sequencer FSM state (CLEAR, IDLE)
//   DEFAULT_DATA_W : default register width
//   DEFAULT_ADDR_W : default address width (DEPTH = 2**ADDR_W)
// ---------------------------------------------------------------------------
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ADDR_W = 5;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// ---------------------------------------------------------------------------
// regfile_clear_seq
// Sequencer that sweeps zeros through every register-file entry, one entry
// per clock, after reset or on request.
// Ports:
//   clk_i        : clock, rising edge
//   rst_n_i      : synchronous active-low reset (restarts the sweep at 0)
//   start_i      : request a new sweep (only honoured in IDLE)
//   clear_we_o   : write-enable for the array write mux (sweep active)
//   clear_addr_o : entry being cleared this edge
//   busy_o       : registered, high while the sweep is in progress
// ---------------------------------------------------------------------------
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W
)
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   output logic              clear_we_o,
   output logic [ADDR_W-1:0] clear_addr_o,
   output logic              busy_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              busy_q, busy_d;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      clear_we_o = 1'b0;
      case (state_q)
         CLEAR: begin
            clear_we_o = 1'b1;
            // The last entry is cleared on the same edge that leaves CLEAR,
            // so the pointer never has to wrap.
            if (ptr_q == LAST_ADDR) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         IDLE: begin
            if (start_i) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
         end
      endcase
      // Busy is taken from the next state so it is a plain register output.
      busy_d = (state_d == CLEAR);
   end

   assign clear_addr_o = ptr_q;
   assign busy_o       = busy_q;

endmodule : regfile_clear_seq

// File: rtl/banco_registradores_multiporta.sv
// ---------------------------------------------------------------------------
// banco_registradores_multiporta
// Parametrised two-read / one-write register file with registered read
// outputs, optional hardwired zero entry and a sequential clear sweep.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding when
// a read and a write hit the same address on the same edge).
// Ports:
//   Clock_in         : clock, rising edge
//   Signal_reset_n   : synchronous active-low reset
//   Read_1 / Read_2  : read addresses, sampled when Read_en=1
//   Read_en          : perform a read on both ports this edge
//   Address_to_write : write address
//   Data_to_write    : write data
//   Signal_write     : write enable
//   Signal_clear     : start a full-array clear sweep
//   Out_1 / Out_2    : registered read data
//   Out_valid        : Out_1/Out_2 were updated at the last edge
//   Busy             : clear sweep in progress
// ---------------------------------------------------------------------------
module banco_registradores_multiporta
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int ZERO_REG = 1
)
(
   input  logic              Clock_in,
   input  logic              Signal_reset_n,
   input  logic [ADDR_W-1:0] Read_1,
   input  logic [ADDR_W-1:0] Read_2,
   input  logic              Read_en,
   input  logic [ADDR_W-1:0] Address_to_write,
   input  logic [DATA_W-1:0] Data_to_write,
   input  logic              Signal_write,
   input  logic              Signal_clear,
   output logic [DATA_W-1:0] Out_1,
   output logic [DATA_W-1:0] Out_2,
   output logic              Out_valid,
   output logic              Busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              clear_we;
   logic [ADDR_W-1:0] clear_addr;
   logic              busy;
   logic              user_we;
   logic              rd_fire;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              valid_q, valid_d;

   regfile_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clk_i        (Clock_in),
      .rst_n_i      (Signal_reset_n),
      .start_i      (Signal_clear),
      .clear_we_o   (clear_we),
      .clear_addr_o (clear_addr),
      .busy_o       (busy)
   );

   // User writes are dropped while sweeping and when targeting the
   // hardwired zero entry.
   assign user_we = Signal_write && !busy
                    && !((ZERO_REG != 0) && (Address_to_write == '0));
   assign rd_fire = Read_en && !busy;

   // Array write mux: the sweep has priority; nothing is written on a reset
   // edge so reset itself leaves the contents alone.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = Address_to_write;
      wr_data = Data_to_write;
      if (Signal_reset_n) begin
         if (clear_we) begin
            wr_en   = 1'b1;
            wr_addr = clear_addr;
            wr_data = '0;
         end else if (user_we) begin
            wr_en = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock_in) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // One identical registered read path per port.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] rd_d, rd_q;

      assign addr = (gi == 0) ? Read_1 : Read_2;

      always_comb begin
         rd_d = rd_q;
         if (rd_fire) begin
            if ((ZERO_REG != 0) && (addr == '0)) begin
               rd_d = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (user_we && (addr == Address_to_write)) begin
               // Forward the word being written this edge.
               rd_d = Data_to_write;
`endif
            end else begin
               rd_d = mem_q[addr];
            end
         end
      end

      always_ff @(posedge Clock_in) begin
         if (!Signal_reset_n) begin
            rd_q <= '0;
         end else begin
            rd_q <= rd_d;
         end
      end
   end

   assign valid_d = rd_fire;

   always_ff @(posedge Clock_in) begin
      if (!Signal_reset_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   assign Out_1     = g_rd[0].rd_q;
   assign Out_2     = g_rd[1].rd_q;
   assign Out_valid = valid_q;
   assign Busy      = busy;

endmodule : banco_registradores_multiporta

// File: tb/tb_banco_registradores_multiporta.sv
// ---------------------------------------------------------------------------
// tb_banco_registradores_multiporta
// Directed self-checking bench for banco_registradores_multiporta with the
// default parameters (32x32, ZERO_REG=1). Read expectations go through a
// scoreboard queue; Busy/Out_valid are checked directly each cycle.
// ---------------------------------------------------------------------------
module tb_banco_registradores_multiporta;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   typedef struct packed {
      logic [DW-1:0] e1;
      logic [DW-1:0] e2;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] rd1, rd2, waddr;
   logic          ren, we, clr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] out1, out2;
   logic          out_valid, busy;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   banco_registradores_multiporta dut (
      .Clock_in         (clk),
      .Signal_reset_n   (rst_n),
      .Read_1           (rd1),
      .Read_2           (rd2),
      .Read_en          (ren),
      .Address_to_write (waddr),
      .Data_to_write    (wdata),
      .Signal_write     (we),
      .Signal_clear     (clr),
      .Out_1            (out1),
      .Out_2            (out2),
      .Out_valid        (out_valid),
      .Busy             (busy)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      we = 1'b1; waddr = a; wdata = d;
      cyc();
      we = 1'b0;
   endtask

   // Read both ports; expected data is queued before the edge and popped
   // once the registered result is visible.
   task automatic rd(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                     input logic [DW-1:0] e1, input logic [DW-1:0] e2);
      exp_t e;
      ren = 1'b1; rd1 = a1; rd2 = a2;
      sb.push_back('{e1: e1, e2: e2});
      cyc();
      ren = 1'b0;
      e = sb.pop_front();
      chk({tag, ".out1"}, out1, e.e1);
      chk({tag, ".out2"}, out2, e.e2);
      chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      $display("read %-10s a1=%0d a2=%0d out1=%h out2=%h", tag, a1, a2, out1, out2);
   endtask

   initial begin
      logic [DW-1:0] exp_byp;
      rst_n = 1'b0; rd1 = '0; rd2 = '0; waddr = '0; wdata = '0;
      ren = 1'b0; we = 1'b0; clr = 1'b0;

      // Reset state
      cyc(); cyc();
      chk("rst.out1", out1, '0);
      chk("rst.out2", out2, '0);
      chk("rst.valid", {31'd0, out_valid}, '0);
      chk("rst.busy", {31'd0, busy}, 32'd1);

      // Sweep after release: Busy for exactly DEPTH edges, reads ignored
      ren = 1'b1; rd1 = 5'd3; rd2 = 5'd3;
      rst_n = 1'b1;
      for (int k = 1; k <= DEPTH; k++) begin
         cyc();
         chk($sformatf("init.busy%0d", k), {31'd0, busy}, (k < DEPTH) ? 32'd1 : 32'd0);
         chk($sformatf("init.valid%0d", k), {31'd0, out_valid}, '0);
      end
      $display("init sweep done busy=%0b", busy);
      rd("init.rd3", 5'd3, 5'd3, '0, '0);

      // Plain write then read
      wr(5'd7, 32'hDEADBEEF);
      rd("rd7", 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF);

      // Read_en=0 holds data, drops valid
      cyc();
      chk("hold.out1", out1, 32'hDEADBEEF);
      chk("hold.valid", {31'd0, out_valid}, '0);

      // Hardwired zero register
      wr(5'd0, 32'h12345678);
      rd("zero", 5'd0, 5'd7, '0, 32'hDEADBEEF);

      // Same-edge write and read of address 9
`ifdef REGFILE_BYPASS_EN
      exp_byp = 32'hA5A5A5A5;
`else
      exp_byp = 32'h0;
`endif
      we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
      rd("same9", 5'd9, 5'd7, exp_byp, 32'hDEADBEEF);
      we = 1'b0;
      rd("after9", 5'd9, 5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5);

      // Fill 1..31 with their index
      for (int i = 1; i < DEPTH; i++) wr(AW'(i), DW'(i));
      rd("fill", 5'd4, 5'd31, 32'd4, 32'd31);

      // Clear pulse with a simultaneous write to 4
      clr = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h55;
      cyc();
      clr = 1'b0; we = 1'b0;
      chk("clr.busy0", {31'd0, busy}, 32'd1);
      for (int k = 1; k <= DEPTH; k++) begin
         // Late writes to an already-cleared entry must be dropped; reads too.
         ren = 1'b1; rd1 = 5'd2; rd2 = 5'd2;
         we = (k > 8); waddr = 5'd2; wdata = 32'h77;
         cyc();
         chk($sformatf("clr.busy%0d", k), {31'd0, busy}, (k < DEPTH) ? 32'd1 : 32'd0);
         chk($sformatf("clr.valid%0d", k), {31'd0, out_valid}, '0);
         chk($sformatf("clr.hold%0d", k), out1, 32'd4);
      end
      ren = 1'b0; we = 1'b0;
      $display("clear sweep done busy=%0b", busy);
      for (int i = 0; i < DEPTH / 2; i++)
         rd($sformatf("z%0d", i), AW'(i), AW'(i + DEPTH / 2), '0, '0);

      // Reset in the middle of a sweep restarts it
      wr(5'd12, 32'h0000BEEF);
      rd("rd12", 5'd12, 5'd12, 32'h0000BEEF, 32'h0000BEEF);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      for (int k = 1; k < 10; k++) cyc();
      rst_n = 1'b0;
      cyc();
      chk("mid.busy", {31'd0, busy}, 32'd1);
      chk("mid.out1", out1, '0);
      chk("mid.valid", {31'd0, out_valid}, '0);
      rst_n = 1'b1;
      for (int k = 1; k <= DEPTH; k++) begin
         cyc();
         chk($sformatf("mid.busy%0d", k), {31'd0, busy}, (k < DEPTH) ? 32'd1 : 32'd0);
      end
      $display("restarted sweep done busy=%0b", busy);
      rd("post", 5'd12, 5'd9, '0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_banco_registradores_multiporta
